// File: rtl/io_timer.sv
// Countdown timer and interrupt source on the core IO bus: prescaler, 32-bit
// down-counter with optional auto-reload, sticky pending flag and a registered irq.
module io_timer #(
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_r,
  input  logic        io_w,
  input  logic [15:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_RELOAD   = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // Register state
  logic                  en;
  logic                  autoreload;
  logic                  ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pc;
  logic [31:0]           count;
  logic [31:0]           reload;
  logic                  pend;

  // Address decode
  logic       sel;
  logic [2:0] off;
  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_count;
  logic       wr_reload;
  logic       wr_status;
  logic       unused_addr_bits;

  assign sel              = (io_addr[15:5] == BASE_ADDR[15:5]);
  assign off              = io_addr[4:2];
  assign unused_addr_bits = ^io_addr[1:0];

  assign wr_ctrl     = io_w && sel && (off == OFF_CTRL);
  assign wr_prescale = io_w && sel && (off == OFF_PRESCALE);
  assign wr_count    = io_w && sel && (off == OFF_COUNT);
  assign wr_reload   = io_w && sel && (off == OFF_RELOAD);
  assign wr_status   = io_w && sel && (off == OFF_STATUS);

  // Timebase events
  logic tick;
  logic underflow;

  assign tick      = en && (pc == prescale);
  assign underflow = tick && (count == '0);

  // Control bits; a CTRL write overrides the one-shot auto-disable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      ie         <= 1'b0;
    end else if (wr_ctrl) begin
      en         <= io_wdata[0];
      autoreload <= io_wdata[1];
      ie         <= io_wdata[2];
    end else if (underflow && !autoreload) begin
      en         <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else if (wr_prescale) begin
      prescale <= io_wdata[PRESCALE_W-1:0];
    end
  end

  // pc sits at 0 whenever EN=0, so an EN 0->1 write always restarts from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (!en || tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  // Bus write to COUNT beats both decrement and reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= io_wdata;
    end else if (tick) begin
      if (count != '0) begin
        count <= count - 1'b1;
      end else if (autoreload) begin
        count <= reload;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload <= '0;
    end else if (wr_reload) begin
      reload <= io_wdata;
    end
  end

  // Sticky pending: a new underflow wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (underflow) begin
      pend <= 1'b1;
    end else if (wr_status && io_wdata[0]) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= pend && ie;
    end
  end

  // Zero when idle so several responders can be OR-combined
  always_comb begin
    io_rdata = '0;
    if (io_r && sel) begin
      case (off)
        OFF_CTRL:     io_rdata = {29'b0, ie, autoreload, en};
        OFF_PRESCALE: io_rdata = 32'(prescale);
        OFF_COUNT:    io_rdata = count;
        OFF_RELOAD:   io_rdata = reload;
        OFF_STATUS:   io_rdata = {31'b0, pend};
        default:      io_rdata = '0;
      endcase
    end
  end

endmodule
